// File: rtl/hero_write_rx.sv
// Receive end of the hero write bus: frames beats into transactions, buffers them in a FIFO
// and streams them to a local consumer, flagging overflow, illegal encodings and over-long transactions.
module hero_write_rx #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [45:0]                  hero_wr_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [35:0]                  out_wdat_o,
  output logic [6:0]                   out_sub_o,
  output logic                         out_last_o,
  output logic                         out_err_o,
  output logic [$clog2(MAX_BEATS)-1:0] out_idx_o,
  output logic                         err_ovf_o,
  output logic                         err_ill_o,
  output logic                         err_long_o,
  input  logic                         err_clr_i,
  output logic [15:0]                  txn_cnt_o
);

  localparam int unsigned IW = $clog2(MAX_BEATS);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [1:0] CT_IDLE  = 2'd0;
  localparam logic [1:0] CT_VALID = 2'd1;
  localparam logic [1:0] CT_DONE  = 2'd2;
  localparam logic [1:0] CT_ILL   = 2'd3;

  typedef enum logic [1:0] {IDLE_S, IN_S, DROP_S} state_t;

  typedef struct packed {
    logic [35:0]   wdat;
    logic [6:0]    sub;
    logic          last;
    logic          err;
    logic [IW-1:0] idx;
  } ent_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  ent_t          mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q;
  logic          err_ovf_q, err_ill_q, err_long_q;
  logic [15:0]   txn_cnt_q;

  logic [1:0] ct_c;
  logic       beat_c;
  logic       room_valid_c, room_done_c;
  logic       push_c, pop_c;
  ent_t       push_ent_c, head_c;
  logic       set_ovf_c, set_ill_c, set_long_c;

  assign ct_c         = hero_wr_i[45:44];
  assign beat_c       = hero_wr_i[0];
  // A pop in the same cycle never frees space for the push.
  assign room_valid_c = (cnt_q <= CW'(DEPTH - 2));
  assign room_done_c  = (cnt_q <  CW'(DEPTH));
  assign pop_c        = valid_q & out_ready_i;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Transaction framing FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE_S;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    push_c          = 1'b0;
    set_ovf_c       = 1'b0;
    set_ill_c       = 1'b0;
    set_long_c      = 1'b0;
    push_ent_c.wdat = hero_wr_i[43:8];
    push_ent_c.sub  = hero_wr_i[7:1];
    push_ent_c.last = 1'b0;
    push_ent_c.err  = 1'b0;
    push_ent_c.idx  = idx_q;
    if (beat_c) begin
      unique case (state_q)
        IDLE_S: begin
          case (ct_c)
            CT_VALID: begin
              if (room_valid_c) begin
                push_c  = 1'b1;
                idx_d   = IW'(1);
                state_d = IN_S;
              end else begin
                set_ovf_c = 1'b1;
                state_d   = DROP_S;
              end
            end
            CT_DONE: begin
              push_ent_c.last = 1'b1;
              if (room_done_c) push_c = 1'b1;
              else             set_ovf_c = 1'b1;
            end
            CT_ILL:  set_ill_c = 1'b1;
            default: ;
          endcase
        end
        IN_S: begin
          case (ct_c)
            CT_VALID: begin
              if (idx_q == IW'(MAX_BEATS - 1)) begin
                set_long_c = 1'b1;
                state_d    = DROP_S;
              end else if (!room_valid_c) begin
                set_ovf_c = 1'b1;
                state_d   = DROP_S;
              end else begin
                push_c = 1'b1;
                idx_d  = idx_q + IW'(1);
              end
            end
            CT_DONE: begin
              push_ent_c.last = 1'b1;
              if (room_done_c) push_c = 1'b1;
              else             set_ovf_c = 1'b1;
              idx_d   = '0;
              state_d = IDLE_S;
            end
            CT_ILL: begin
              set_ill_c = 1'b1;
              state_d   = DROP_S;
            end
            default: ;
          endcase
        end
        DROP_S: begin
          case (ct_c)
            CT_DONE: begin
              // Guard kept: a drop entered from IDLE_S on a full FIFO may still be full here.
              push_ent_c.last = 1'b1;
              push_ent_c.err  = 1'b1;
              if (room_done_c) push_c = 1'b1;
              else             set_ovf_c = 1'b1;
              idx_d   = '0;
              state_d = IDLE_S;
            end
            CT_ILL:  set_ill_c = 1'b1;
            default: ;
          endcase
        end
        default: state_d = IDLE_S;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push_c && !pop_c)      cnt_d = cnt_q + CW'(1);
    else if (!push_c && pop_c) cnt_d = cnt_q - CW'(1);
  end

  // FIFO storage and pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_c) begin
        mem_q[wr_ptr_q] <= push_ent_c;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_c) rd_ptr_q <= ptr_inc(rd_ptr_q);
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
    end
  end

  // Sticky error flags and terminator count; clear wins over set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_ovf_q  <= 1'b0;
      err_ill_q  <= 1'b0;
      err_long_q <= 1'b0;
      txn_cnt_q  <= '0;
    end else begin
      err_ovf_q  <= ~err_clr_i & (err_ovf_q  | set_ovf_c);
      err_ill_q  <= ~err_clr_i & (err_ill_q  | set_ill_c);
      err_long_q <= ~err_clr_i & (err_long_q | set_long_c);
      txn_cnt_q  <= txn_cnt_q + 16'(push_c & push_ent_c.last);
    end
  end

  assign head_c      = mem_q[rd_ptr_q];
  assign out_valid_o = valid_q;
  assign out_wdat_o  = head_c.wdat;
  assign out_sub_o   = head_c.sub;
  assign out_last_o  = head_c.last;
  assign out_err_o   = head_c.err;
  assign out_idx_o   = head_c.idx;
  assign err_ovf_o   = err_ovf_q;
  assign err_ill_o   = err_ill_q;
  assign err_long_o  = err_long_q;
  assign txn_cnt_o   = txn_cnt_q;

endmodule
